clm_modp_unit: RTL and testbench

// Multi-lane sequential GF(2)[x] unit on redundant CLM bytes (8+D bits, degree < 8+D).

---
 rtl/clm_modp_unit.sv | 96 +++++++++
 tb/tb_clm_modp_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clm_modp_unit.sv
// Multi-lane sequential GF(2)[x] unit on redundant CLM bytes: folds each (8+D)-bit lane mod P
// (REDUCE) or adds r*P to it (REFRESH), one coefficient per clock, D clocks per operation.
module clm_modp_unit #(
  parameter int D     = 4,
  parameter int LANES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     drdy_i,
  input  logic                     mode,
  input  logic [0:8]               P,
  input  logic [0:LANES*(8+D)-1]   in,
  input  logic [0:LANES*D-1]       r,
  output logic [0:LANES*(8+D)-1]   out,
  output logic                     drdy_o,
  output logic                     busy
);

  localparam int W  = 8 + D;
  localparam int CW = $clog2(D + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]             r_state;
  logic [CW-1:0]          r_ctr;
  logic [0:LANES*W-1]     r_acc;
  logic [0:LANES*D-1]     r_rr;
  logic [0:8]             r_pq;
  logic                   r_mq;
  logic [0:LANES*W-1]     r_out;
  logic                   r_drdy;

  logic [CW-1:0]          w_j;
  logic [0:W-1]           w_lane;
  logic                   w_cond;
  logic [0:LANES*W-1]     w_step;

  // Bit index 0 of each lane is its highest-degree coefficient, so step j clears from the top down.
  assign w_j = (r_ctr < CW'(D)) ? r_ctr : '0;

  // NOTE: every combinational temporary gets a default before use, so no latch can be inferred.
  always_comb begin
    w_step = r_acc;
    w_lane = '0;
    w_cond = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      w_lane = r_acc[l*W +: W];
      w_cond = r_mq ? r_rr[l*D + int'(w_j)] : w_lane[w_j];
      if (w_cond) w_lane[w_j +: 9] = w_lane[w_j +: 9] ^ r_pq;
      w_step[l*W +: W] = w_lane;
    end
  end

  // NOTE: state uses non-blocking assignments; the whole datapath is cleared on reset so out reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ctr   <= '0;
      r_acc   <= '0;
      r_rr    <= '0;
      r_pq    <= '0;
      r_mq    <= 1'b0;
      r_out   <= '0;
      r_drdy  <= 1'b0;
    end else begin
      r_drdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (drdy_i) begin
            r_acc   <= in;
            r_rr    <= r;
            r_pq    <= P;
            r_mq    <= mode;
            r_ctr   <= '0;
            r_state <= S_RUN;
          end
        end
        default: begin
          r_acc <= w_step;
          r_ctr <= r_ctr + CW'(1);
          if (r_ctr == CW'(D - 1)) begin
            r_out   <= w_step;
            r_drdy  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign out    = r_out;
  assign drdy_o = r_drdy;
  assign busy   = (r_state == S_RUN);

endmodule

// File: tb/tb_clm_modp_unit.sv
// Directed and random bench for clm_modp_unit: a D=4/16-lane instance for the directed cases,
// plus D=1/1-lane and D=8/4-lane instances for the random regression against a polynomial model.
module tb_clm_modp_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance: D=4, 16 lanes of 12 bits
  logic          drdy_i4 = 1'b0, mode4 = 1'b0;
  logic [0:8]    p4 = '0;
  logic [0:191]  in4 = '0;
  logic [0:63]   r4 = '0;
  logic [0:191]  out4;
  logic          drdy_o4, busy4;

  clm_modp_unit #(.D(4), .LANES(16)) u4 (
    .clk(clk), .rst(rst), .drdy_i(drdy_i4), .mode(mode4), .P(p4), .in(in4), .r(r4),
    .out(out4), .drdy_o(drdy_o4), .busy(busy4));

  // D=1, 1 lane of 9 bits
  logic          drdy_i1 = 1'b0, mode1 = 1'b0;
  logic [0:8]    p1 = '0;
  logic [0:8]    in1 = '0;
  logic [0:0]    r1 = '0;
  logic [0:8]    out1;
  logic          drdy_o1, busy1;

  clm_modp_unit #(.D(1), .LANES(1)) u1 (
    .clk(clk), .rst(rst), .drdy_i(drdy_i1), .mode(mode1), .P(p1), .in(in1), .r(r1),
    .out(out1), .drdy_o(drdy_o1), .busy(busy1));

  // D=8, 4 lanes of 16 bits
  logic          drdy_i8 = 1'b0, mode8 = 1'b0;
  logic [0:8]    p8 = '0;
  logic [0:63]   in8 = '0;
  logic [0:31]   r8 = '0;
  logic [0:63]   out8;
  logic          drdy_o8, busy8;

  clm_modp_unit #(.D(8), .LANES(4)) u8 (
    .clk(clk), .rst(rst), .drdy_i(drdy_i8), .mode(mode8), .P(p8), .in(in8), .r(r8),
    .out(out8), .drdy_o(drdy_o8), .busy(busy8));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Polynomial reference: values are plain integers, bit k = coefficient of x^k.
  function automatic logic [15:0] model(input int d, input logic m, input logic [8:0] p,
                                        input logic [15:0] v, input logic [7:0] rv);
    logic [15:0] acc;
    acc = v;
    if (m) begin
      for (int b = 0; b < d; b++)
        if (rv[b]) acc = acc ^ (16'(p) << b);
    end else begin
      for (int k = 7 + d; k >= 8; k--)
        if (acc[k]) acc = acc ^ (16'(p) << (k - 8));
    end
    return acc;
  endfunction

  function automatic logic [0:191] rep4(input logic [11:0] v);
    logic [0:191] res;
    for (int i = 0; i < 16; i++) res[i*12 +: 12] = v;
    return res;
  endfunction

  function automatic logic [0:63] rep_r4(input logic [3:0] v);
    logic [0:63] res;
    for (int i = 0; i < 16; i++) res[i*4 +: 4] = v;
    return res;
  endfunction

  // cyc counts falling edges from the one after drdy_i is raised; D+1 means drdy_o after D edges
  task automatic op4(input logic m, input logic [8:0] p, input logic [0:191] iv,
                     input logic [0:63] rv, output int cyc);
    @(negedge clk);
    mode4 = m; p4 = p; in4 = iv; r4 = rv; drdy_i4 = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      drdy_i4 = 1'b0;
      cyc++;
    end while (!drdy_o4 && cyc < 20);
  endtask

  task automatic op1(input logic m, input logic [8:0] p, input logic [0:8] iv,
                     input logic [0:0] rv, output int cyc);
    @(negedge clk);
    mode1 = m; p1 = p; in1 = iv; r1 = rv; drdy_i1 = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      drdy_i1 = 1'b0;
      cyc++;
    end while (!drdy_o1 && cyc < 20);
  endtask

  task automatic op8(input logic m, input logic [8:0] p, input logic [0:63] iv,
                     input logic [0:31] rv, output int cyc);
    @(negedge clk);
    mode8 = m; p8 = p; in8 = iv; r8 = rv; drdy_i8 = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      drdy_i8 = 1'b0;
      cyc++;
    end while (!drdy_o8 && cyc < 20);
  endtask

  typedef struct {
    string       name;
    logic        m;
    logic [8:0]  p;
    logic [11:0] v;
    logic [3:0]  rv;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cyc;
    logic [0:191] t_in, t_exp, t_hold;
    logic [0:63]  t_r;
    logic [14:0]  busy_act, busy_exp, drdy_act, drdy_exp;
    int n_drdy;
    logic ok;

    vecs[0] = '{"red_x8",        1'b0, 9'h11B, 12'h100, 4'h0, 12'h01B};
    vecs[1] = '{"red_px3",       1'b0, 9'h11B, 12'h8D8, 4'h0, 12'h000};
    vecs[2] = '{"red_passthru",  1'b0, 9'h11B, 12'h0FF, 4'h0, 12'h0FF};
    vecs[3] = '{"red_fff",       1'b0, 9'h11B, 12'hFFF, 4'h0, 12'h066};
    vecs[4] = '{"ref_r1",        1'b1, 9'h11B, 12'h053, 4'h1, 12'h148};
    vecs[5] = '{"ref_r8",        1'b1, 9'h11B, 12'h053, 4'h8, 12'h88B};
    vecs[6] = '{"ref_r0",        1'b1, 9'h11B, 12'h053, 4'h0, 12'h053};
    vecs[7] = '{"red_rt148",     1'b0, 9'h11B, 12'h148, 4'h0, 12'h053};
    vecs[8] = '{"red_rt88b",     1'b0, 9'h11B, 12'h88B, 4'h0, 12'h053};
    vecs[9] = '{"red_nonmonic",  1'b0, 9'h01B, 12'h100, 4'h0, 12'h11B};

    // Reset state
    #1;
    check("reset_state", {out4, busy4, drdy_o4}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Uniform-lane directed vectors
    for (int i = 0; i < 10; i++) begin
      op4(vecs[i].m, vecs[i].p, rep4(vecs[i].v), rep_r4(vecs[i].rv), cyc);
      check({vecs[i].name, "_lat"}, 192'(cyc), 192'(5));
      check(vecs[i].name, out4, rep4(vecs[i].exp));
    end

    // Mixed lanes: independence across lanes
    t_in = rep4(12'h100);
    t_in[0 +: 12] = 12'h8D8;
    t_in[12 +: 12] = 12'h0FF;
    t_in[24 +: 12] = 12'hFFF;
    t_exp = rep4(12'h01B);
    t_exp[0 +: 12] = 12'h000;
    t_exp[12 +: 12] = 12'h0FF;
    t_exp[24 +: 12] = 12'(model(4, 1'b0, 9'h11B, 16'h0FFF, 8'h00));
    op4(1'b0, 9'h11B, t_in, '0, cyc);
    check("mixed_lanes", out4, t_exp);

    // drdy_i held high: one capture every 5 cycles, busy 4 of each 5, 1-cycle drdy_o
    @(negedge clk);
    mode4 = 1'b0; p4 = 9'h11B; in4 = rep4(12'h100); r4 = '0; drdy_i4 = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      busy_act[k-1] = busy4;
      drdy_act[k-1] = drdy_o4;
      busy_exp[k-1] = (k % 5 != 0);
      drdy_exp[k-1] = (k % 5 == 0);
    end
    drdy_i4 = 1'b0;
    check("held_busy_pattern", 192'(busy_act), 192'(busy_exp));
    check("held_drdy_pattern", 192'(drdy_act), 192'(drdy_exp));
    check("held_result", out4, rep4(12'h01B));

    // Inputs changed during RUN, plus a drdy_i pulse on busy and at E_D, are ignored
    @(negedge clk);
    mode4 = 1'b0; p4 = 9'h11B; in4 = rep4(12'h100); r4 = '0; drdy_i4 = 1'b1;
    @(negedge clk);
    mode4 = 1'b1; p4 = 9'h1FF; in4 = rep4(12'hFFF); r4 = '1;
    cyc = 1;
    while (!drdy_o4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) drdy_i4 = 1'b0;
    end
    drdy_i4 = 1'b0;
    check("midrun_lat", 192'(cyc), 192'(5));
    check("midrun_result", out4, rep4(12'h01B));
    ok = 1'b1;
    t_hold = out4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out4 !== t_hold || drdy_o4 !== 1'b0 || busy4 !== 1'b0) ok = 1'b0;
    end
    check("out_stable_idle", 192'(ok), 192'(1));
    check("out_stable_value", out4, rep4(12'h01B));

    // Asynchronous reset mid-operation
    @(negedge clk);
    mode4 = 1'b0; p4 = 9'h11B; in4 = rep4(12'h148); r4 = '0; drdy_i4 = 1'b1;
    @(negedge clk);
    drdy_i4 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset", {out4, busy4, drdy_o4}, '0);
    @(negedge clk);
    rst = 1'b0;
    n_drdy = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (drdy_o4) n_drdy++;
    end
    check("no_late_drdy", 192'(n_drdy), 192'(0));
    op4(1'b0, 9'h11B, rep4(12'h148), '0, cyc);
    check("post_reset_lat", 192'(cyc), 192'(5));
    check("post_reset_result", out4, rep4(12'h053));

    // Random regression across the three configurations
    for (int it = 0; it < 12; it++) begin
      logic m;
      logic [8:0] p;
      m = 1'($urandom);
      p = {1'b1, 8'($urandom)};
      for (int l = 0; l < 16; l++) begin
        logic [11:0] v;
        logic [3:0]  rv;
        v  = 12'($urandom);
        rv = 4'($urandom);
        t_in[l*12 +: 12] = v;
        t_r[l*4 +: 4] = rv;
        t_exp[l*12 +: 12] = 12'(model(4, m, p, 16'(v), 8'(rv)));
      end
      op4(m, p, t_in, t_r, cyc);
      check("rand_d4_lat", 192'(cyc), 192'(5));
      check("rand_d4", out4, t_exp);
    end

    for (int it = 0; it < 12; it++) begin
      logic m;
      logic [8:0] p, v, e;
      logic rv;
      m  = 1'($urandom);
      p  = {1'b1, 8'($urandom)};
      v  = 9'($urandom);
      rv = 1'($urandom);
      e  = 9'(model(1, m, p, 16'(v), 8'(rv)));
      op1(m, p, v, rv, cyc);
      check("rand_d1_lat", 192'(cyc), 192'(2));
      check("rand_d1", 192'(out1), 192'(e));
    end

    for (int it = 0; it < 12; it++) begin
      logic m;
      logic [8:0] p;
      logic [0:63] i8, e8;
      logic [0:31] rr8;
      m = 1'($urandom);
      p = {1'b1, 8'($urandom)};
      for (int l = 0; l < 4; l++) begin
        logic [15:0] v;
        logic [7:0]  rv;
        v  = 16'($urandom);
        rv = 8'($urandom);
        i8[l*16 +: 16] = v;
        rr8[l*8 +: 8] = rv;
        e8[l*16 +: 16] = model(8, m, p, v, rv);
      end
      op8(m, p, i8, rr8, cyc);
      check("rand_d8_lat", 192'(cyc), 192'(9));
      check("rand_d8", 192'(out8), 192'(e8));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
